sbox_stream_sched: RTL and testbench

SBOX_STREAM_SCHED -- requirements
Module: sbox_stream_sched

---
 rtl/sbox_stream_pkg.sv | 33 +++
 rtl/sbox_lut_comb.sv | 14 +
 rtl/sbox_stream_sched.sv | 180 ++++++++++++++++++
 tb/tb_sbox_stream_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sbox_stream_pkg.sv
// Shared definitions for the S-box keystream scheduler: FSM states,
// the substitution width and the AES forward S-box table.
package sbox_stream_pkg;

  localparam int SBOX_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    EMIT = 2'd2
  } sched_state_e;

  // AES forward substitution table, entry n is S(n).
  localparam logic [SBOX_W-1:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/sbox_lut_comb.sv
// Combinational AES S-box: a single table read from the shared package.
module sbox_lut_comb
  import sbox_stream_pkg::*;
(
  input  logic [SBOX_W-1:0] lookup,
  output logic [SBOX_W-1:0] subst
);

  // One substitution per evaluation, no state.
  always_comb begin
    subst = SBOX_TABLE[lookup];
  end

endmodule

// File: rtl/sbox_stream_sched.sv
// Keystream scheduler: NBYTES state bytes share one S-box, updated one
// byte per MIX step; after the last step a keystream byte is offered in
// EMIT until the consumer takes it.
// Build option: define SBOX_STREAM_PIPE_EN to register the S-box output;
// every MIX step then takes two cycles (look up, then write back).
module sbox_stream_sched
  import sbox_stream_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                seed_valid,
  output logic                seed_ready,
  input  logic [8*NBYTES-1:0] seed_data,
  input  logic                halt,
  output logic                ks_valid,
  input  logic                ks_ready,
  output logic [7:0]          ks_data,
  output logic                busy,
  output logic [7:0]          round_cnt
);

  localparam int             IDX_W    = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  sched_state_e      state_r, state_nxt_s;
  logic [SBOX_W-1:0] s_r [NBYTES];
  logic [IDX_W-1:0]  idx_r, idx_inc_s;
  logic [7:0]        round_cnt_r, ks_data_r;
  logic              seed_ready_r, busy_r, ks_valid_r;
  logic              seed_ready_d_s, busy_d_s, ks_valid_d_s;
  logic [SBOX_W-1:0] lookup_s, subst_s, step_val_s;
  logic              step_done_s, last_step_s, seed_take_s, ks_take_s;

  sbox_lut_comb u_sbox (
    .lookup (lookup_s),
    .subst  (subst_s)
  );

  // Neighbour index wraps modulo NBYTES; also the next byte to update.
  always_comb begin
    if (idx_r == LAST_IDX) begin
      idx_inc_s = '0;
    end else begin
      idx_inc_s = idx_r + IDX_W'(1);
    end
  end

  // S-box operand: current byte, its neighbour (already updated for the
  // last byte, since s[0] was rewritten first) and the round counter.
  always_comb begin
    lookup_s = s_r[idx_r] ^ s_r[idx_inc_s] ^ round_cnt_r;
  end

`ifdef SBOX_STREAM_PIPE_EN
  logic              phase_r;
  logic [SBOX_W-1:0] subst_r;

  // Two-phase MIX step: capture the lookup, then write it back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_r <= 1'b0;
      subst_r <= 8'h00;
    end else if (state_r == MIX) begin
      phase_r <= ~phase_r;
      if (!phase_r) begin
        subst_r <= subst_s;
      end
    end else begin
      phase_r <= 1'b0;
    end
  end

  // Write-back happens on the second phase from the captured value.
  always_comb begin
    step_val_s  = subst_r;
    step_done_s = (state_r == MIX) && phase_r;
  end
`else
  // Single-cycle MIX step straight from the combinational lookup.
  always_comb begin
    step_val_s  = subst_s;
    step_done_s = (state_r == MIX);
  end
`endif

  // Handshake and step qualifiers used by both FSM and datapath.
  always_comb begin
    last_step_s = step_done_s && (idx_r == LAST_IDX);
    seed_take_s = (state_r == IDLE) && seed_valid;
    ks_take_s   = (state_r == EMIT) && ks_ready;
  end

  // FSM state register plus registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      seed_ready_r <= 1'b1;
      busy_r       <= 1'b0;
      ks_valid_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      seed_ready_r <= seed_ready_d_s;
      busy_r       <= busy_d_s;
      ks_valid_r   <= ks_valid_d_s;
    end
  end

  // Next-state: halt only matters at the keystream handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (seed_take_s) state_nxt_s = MIX;
        else             state_nxt_s = IDLE;
      end
      MIX: begin
        if (last_step_s) state_nxt_s = EMIT;
        else             state_nxt_s = MIX;
      end
      EMIT: begin
        if (ks_take_s) state_nxt_s = halt ? IDLE : MIX;
        else           state_nxt_s = EMIT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Status decode of the upcoming state, registered above.
  always_comb begin
    seed_ready_d_s = 1'b1;
    busy_d_s       = 1'b0;
    ks_valid_d_s   = 1'b0;
    case (state_nxt_s)
      IDLE: begin
        seed_ready_d_s = 1'b1; busy_d_s = 1'b0; ks_valid_d_s = 1'b0;
      end
      MIX: begin
        seed_ready_d_s = 1'b0; busy_d_s = 1'b1; ks_valid_d_s = 1'b0;
      end
      EMIT: begin
        seed_ready_d_s = 1'b0; busy_d_s = 1'b1; ks_valid_d_s = 1'b1;
      end
      default: begin
        seed_ready_d_s = 1'b1; busy_d_s = 1'b0; ks_valid_d_s = 1'b0;
      end
    endcase
  end

  // Datapath: seed load, byte update per step, round advance on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NBYTES; i++) s_r[i] <= 8'h00;
      idx_r       <= '0;
      round_cnt_r <= 8'h00;
      ks_data_r   <= 8'h00;
    end else if (seed_take_s) begin
      for (int i = 0; i < NBYTES; i++) s_r[i] <= seed_data[8*i +: 8];
      idx_r       <= '0;
      round_cnt_r <= 8'h00;
    end else if (step_done_s) begin
      s_r[idx_r] <= step_val_s;
      idx_r      <= idx_inc_s;
      if (last_step_s) begin
        ks_data_r <= step_val_s ^ s_r[0];
      end
    end else if (ks_take_s) begin
      round_cnt_r <= round_cnt_r + 8'd1;
      idx_r       <= '0;
    end
  end

  assign seed_ready = seed_ready_r;
  assign busy       = busy_r;
  assign ks_valid   = ks_valid_r;
  assign ks_data    = ks_data_r;
  assign round_cnt  = round_cnt_r;

endmodule

// File: tb/tb_sbox_stream_sched.sv
// Scoreboard bench for sbox_stream_sched (NBYTES=4). The reference S-box
// is computed from GF(2^8) inversion plus the AES affine map.
`timescale 1ns/1ps
module tb_sbox_stream_sched;
  localparam int NB = 4;
`ifdef SBOX_STREAM_PIPE_EN
  localparam int PF = 2;
`else
  localparam int PF = 1;
`endif
  localparam int LAT = NB * PF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          seed_valid = 1'b0;
  logic          halt = 1'b0;
  logic          ks_ready = 1'b0;
  logic [8*NB-1:0] seed_data = '0;
  logic          seed_ready, ks_valid, busy;
  logic [7:0]    ks_data, round_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed { logic [7:0] ks; logic [7:0] rc; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sbox_stream_sched #(.NBYTES(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .seed_data  (seed_data),
    .halt       (halt),
    .ks_valid   (ks_valid),
    .ks_ready   (ks_ready),
    .ks_data    (ks_data),
    .busy       (busy),
    .round_cnt  (round_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in, b = b_in, p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] r = 8'h01, base = x, inv;
    int e = 254;
    while (e > 0) begin
      if (e % 2 == 1) r = gmul(r, base);
      base = gmul(base, base);
      e = e / 2;
    end
    inv = r;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Expected keystream for a whole session, straight from the round rule.
  task automatic push_session(input logic [8*NB-1:0] seed, input int nrounds);
    logic [7:0] ms [NB];
    logic [7:0] rc = 8'h00;
    for (int i = 0; i < NB; i++) ms[i] = seed[8*i +: 8];
    for (int r = 0; r < nrounds; r++) begin
      for (int i = 0; i < NB; i++) ms[i] = sbox_ref(ms[i] ^ ms[(i + 1) % NB] ^ rc);
      exp_q.push_back({ms[NB-1] ^ ms[0], rc});
      rc = rc + 8'd1;
    end
  endtask

  // Monitor: each new keystream presentation is popped and compared.
  bit         shown = 1'b0;
  int         lat_cnt = 0;
  logic [7:0] held = 8'h00;
  exp_t       e;
  always @(negedge clk) begin
    if (!rst_n || !busy) begin
      lat_cnt = 0;
      shown   = 1'b0;
    end else if (!ks_valid) begin
      lat_cnt++;
      shown = 1'b0;
    end else if (!shown) begin
      check("latency", lat_cnt, LAT);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ks: got %0h, expected no output", ks_data);
      end else begin
        e = exp_q.pop_front();
        check("ks_data", ks_data, e.ks);
        check("round_cnt", round_cnt, e.rc);
      end
      held    = ks_data;
      shown   = 1'b1;
      lat_cnt = 0;
    end else begin
      check("ks_hold", ks_data, held);
    end
  end

  // One seed-to-halt session with random ready/halt/seed noise.
  task automatic run_session(input logic [8*NB-1:0] seed, input int nrounds,
                             input int pct, input bit stall_first);
    int left = nrounds;
    int stall = stall_first ? 10 : 0;
    int budget = nrounds * (LAT + 60) + 100;
    push_session(seed, nrounds);
    @(negedge clk);
    check("seed_ready_idle", seed_ready, 1);
    seed_valid = 1'b1; seed_data = seed; halt = 1'($urandom); ks_ready = 1'($urandom);
    @(negedge clk);
    check("busy_after_seed", busy, 1);
    check("seed_ready_busy", seed_ready, 0);
    while (left > 0 && budget > 0) begin
      seed_valid = 1'($urandom);
      seed_data  = $urandom;
      if (ks_valid) begin
        halt = (left == 1);
        if (stall > 0) begin
          ks_ready = 1'b0;
          check("stall_ks_data", ks_data, 8'h98);
          check("stall_round", round_cnt, 0);
          check("stall_busy", busy, 1);
          stall--;
        end else begin
          ks_ready = ($urandom_range(99) < pct);
          if (ks_ready) left--;
        end
      end else begin
        halt     = 1'($urandom);
        ks_ready = 1'($urandom);
      end
      @(negedge clk);
      budget--;
    end
    if (left > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL session_timeout: got %0d rounds left, expected 0", left);
      exp_q.delete();
    end
    seed_valid = 1'b0; halt = 1'b0; ks_ready = 1'b0;
    check("halt_seed_ready", seed_ready, 1);
    check("halt_busy", busy, 0);
    check("halt_ks_valid", ks_valid, 0);
  endtask

  // Reset pulse in the middle of the third MIX step of a round.
  task automatic reset_mid_mix();
    @(negedge clk);
    seed_valid = 1'b1; seed_data = $urandom; ks_ready = 1'b1; halt = 1'b0;
    @(negedge clk);
    seed_valid = 1'b0;
    repeat (2 * PF) @(negedge clk);
    check("mix_busy_pre_reset", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_seed_ready", seed_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_ks_valid", ks_valid, 0);
    check("rst_ks_data", ks_data, 8'h00);
    check("rst_round", round_cnt, 0);
    repeat (LAT + 2) @(negedge clk);
    check("rst_no_output", ks_valid, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("init_seed_ready", seed_ready, 1);
    check("init_busy", busy, 0);
    check("init_ks_valid", ks_valid, 0);
    check("init_ks_data", ks_data, 8'h00);
    check("init_round", round_cnt, 0);
    rst_n = 1'b1;
    run_session('0, 258, 100, 1'b1);
    for (int k = 0; k < 6; k++) begin
      run_session($urandom, $urandom_range(12, 1), 60, 1'b0);
    end
    reset_mid_mix();
    run_session('0, 1, 100, 1'b0);
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
